// File: rtl/fft_frame_capture.sv
// Purpose: captures one FFT frame on request, sign-extends real/imag samples into the result FIFOs; Avalon-MM CSR control.
// Latency: 1 cycle from accepted sink sample to real/imag_valid; csr_readdata is combinational on csr_address.
// Backpressure: none (no ready on the sink); samples outside a capture are dropped; at most FRAME_LEN words per capture.
// Optional: define FFT_CAPTURE_SCALE_EN for a CSR-programmable rounding arithmetic right shift on each sample.
module fft_frame_capture #(
    parameter int IN_W      = 16,
    parameter int FRAME_LEN = 128,
    parameter int CNT_W     = 8
) (
    input  logic            wrclock,
    input  logic            reset_n,
    input  logic [IN_W-1:0] sink_real,
    input  logic [IN_W-1:0] sink_imag,
    input  logic            sink_valid,
    input  logic            sink_sop,
    input  logic            sink_eop,
    output logic [31:0]     real_data,
    output logic            real_valid,
    output logic [31:0]     imag_data,
    output logic            imag_valid,
    input  logic [1:0]      csr_address,
    input  logic            csr_write,
    input  logic [31:0]     csr_writedata,
    input  logic            csr_read,
    output logic [31:0]     csr_readdata,
    output logic            irq
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LP_LEN = CNT_W'(FRAME_LEN);

    state_t           r_state;
    logic [CNT_W-1:0] r_count;
    logic             r_short;
    logic             r_long;
    logic             r_soperr;
    logic             r_irq_en;
    logic [31:0]      r_real_data;
    logic [31:0]      r_imag_data;
    logic             r_valid;

    logic             w_ctrl_wr;
    logic             w_arm;
    logic             w_abort;
    logic             w_sop_hit;
    logic             w_cap_hit;
    logic             w_sop_err;
    logic             w_accept;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic signed [IN_W-1:0] w_real_s;
    logic signed [IN_W-1:0] w_imag_s;
    logic signed [31:0]     w_real_ext;
    logic signed [31:0]     w_imag_ext;
    logic [31:0]      w_real_out;
    logic [31:0]      w_imag_out;
    logic             w_unused_ok;

    assign w_ctrl_wr = csr_write && (csr_address == 2'd0);
    assign w_arm     = w_ctrl_wr && csr_writedata[0];
    assign w_abort   = w_ctrl_wr && csr_writedata[1];

    // sop in ARMED starts a frame; sop inside CAPTURE is a framing error and is never written
    assign w_sop_hit = (r_state == S_ARMED) && sink_valid && sink_sop;
    assign w_cap_hit = (r_state == S_CAPTURE) && sink_valid && !sink_sop;
    assign w_sop_err = (r_state == S_CAPTURE) && sink_valid && sink_sop;
    // an abort in the same cycle as a sample wins, so that sample is dropped
    assign w_accept  = !w_abort && (w_sop_hit || w_cap_hit);
    assign w_cnt_nxt = w_sop_hit ? CNT_W'(1) : r_count + CNT_W'(1);

    assign w_real_s   = sink_real;
    assign w_imag_s   = sink_imag;
    assign w_real_ext = 32'(w_real_s);
    assign w_imag_ext = 32'(w_imag_s);

`ifdef FFT_CAPTURE_SCALE_EN
    localparam logic signed [32:0] SAT_MAX = 33'sh0_7FFF_FFFF;
    localparam logic signed [32:0] SAT_MIN = 33'sh1_8000_0000;

    logic [4:0] r_shift;

    // round-half-up arithmetic shift, evaluated at 33 bits so the rounding add cannot wrap
    function automatic logic [31:0] f_scale(input logic signed [31:0] x, input logic [4:0] sh);
        logic signed [32:0] v;
        logic [31:0]        res;
        v = 33'(x);
        if (sh != 5'd0) v = v + (33'sd1 <<< (sh - 5'd1));
        v = v >>> sh;
        if (v > SAT_MAX)      res = 32'h7FFF_FFFF;
        else if (v < SAT_MIN) res = 32'h8000_0000;
        else                  res = v[31:0];
        return res;
    endfunction

    // shift amount register, written through the FRAME_LEN address
    always_ff @(posedge wrclock or negedge reset_n) begin
        if (!reset_n)                                r_shift <= 5'd0;
        else if (csr_write && csr_address == 2'd3)   r_shift <= csr_writedata[4:0];
    end

    assign w_real_out = f_scale(w_real_ext, r_shift);
    assign w_imag_out = f_scale(w_imag_ext, r_shift);
`else
    assign w_real_out = w_real_ext;
    assign w_imag_out = w_imag_ext;
`endif

    // capture FSM: abort beats arm, arm only from IDLE/DONE, frame end checks use the post-write count
    always_ff @(posedge wrclock or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_count  <= '0;
            r_short  <= 1'b0;
            r_long   <= 1'b0;
            r_soperr <= 1'b0;
            r_irq_en <= 1'b0;
        end else begin
            if (w_ctrl_wr) r_irq_en <= csr_writedata[2];
            if (w_abort) begin
                r_state <= S_IDLE;
            end else if (w_arm && (r_state == S_IDLE || r_state == S_DONE)) begin
                r_state  <= S_ARMED;
                r_count  <= '0;
                r_short  <= 1'b0;
                r_long   <= 1'b0;
                r_soperr <= 1'b0;
            end else if (w_accept) begin
                r_count <= w_cnt_nxt;
                if (sink_eop) begin
                    r_state <= S_DONE;
                    r_short <= (w_cnt_nxt < LP_LEN);
                end else if (w_cnt_nxt == LP_LEN) begin
                    r_state <= S_DONE;
                    r_long  <= 1'b1;
                end else begin
                    r_state <= S_CAPTURE;
                end
            end else if (w_sop_err) begin
                r_state  <= S_DONE;
                r_soperr <= 1'b1;
            end
        end
    end

    // registered output path; data holds its last value between pulses
    always_ff @(posedge wrclock or negedge reset_n) begin
        if (!reset_n) begin
            r_valid     <= 1'b0;
            r_real_data <= 32'd0;
            r_imag_data <= 32'd0;
        end else begin
            r_valid <= w_accept;
            if (w_accept) begin
                r_real_data <= w_real_out;
                r_imag_data <= w_imag_out;
            end
        end
    end

    assign real_data  = r_real_data;
    assign imag_data  = r_imag_data;
    assign real_valid = r_valid;
    assign imag_valid = r_valid;
    assign irq        = (r_state == S_DONE) && r_irq_en;

    // zero-wait-state read mux; reads have no side effects
    always_comb begin
        csr_readdata = 32'd0;
        case (csr_address)
            2'd0: csr_readdata = {29'd0, r_irq_en, 2'b00};
            2'd1: csr_readdata = {25'd0, r_soperr, r_long, r_short, 2'b00, r_state};
            2'd2: csr_readdata = 32'(r_count);
`ifdef FFT_CAPTURE_SCALE_EN
            2'd3: csr_readdata = {11'd0, r_shift, 16'(FRAME_LEN)};
`else
            2'd3: csr_readdata = 32'(FRAME_LEN);
`endif
            default: csr_readdata = 32'd0;
        endcase
    end

    assign w_unused_ok = ^{csr_read, csr_writedata};

endmodule

// File: doc/fft_frame_capture.md
Name: fft_frame_capture

Overview:
- Sits directly upstream of the real and imaginary FFT result FIFOs (128 × 32-bit, Avalon-ST sink, Avalon-MM read-out).
- Takes the FFT core's Avalon-ST source stream and captures exactly one frame on software request.
- Sign-extends each real/imag sample to 32 bits and pushes it into both FIFOs.
- Never writes more than FRAME_LEN words, so the downstream FIFOs cannot overflow. Control/status goes through a small Avalon-MM slave.

Parameters:
- IN_W, 16, width of signed real/imag samples from the FFT core (2..32)
- FRAME_LEN, 128, maximum samples written per capture; must not exceed FIFO depth
- CNT_W, 8, counter width; must satisfy 2^CNT_W > FRAME_LEN

Ports:
- wrclock  in  1  single clock for all logic
- reset_n  in  1  asynchronous active-low reset
- sink_real  in  IN_W  FFT real part, signed
- sink_imag  in  IN_W  FFT imaginary part, signed
- sink_valid  in  1  sample qualifier
- sink_sop  in  1  first sample of an FFT frame
- sink_eop  in  1  last sample of an FFT frame
- real_data  out  32  to real FIFO avalonst_sink_data
- real_valid  out  1  to real FIFO avalonst_sink_valid
- imag_data  out  32  to imag FIFO avalonst_sink_data
- imag_valid  out  1  to imag FIFO avalonst_sink_valid
- csr_address  in  2  register select
- csr_write  in  1  write strobe
- csr_writedata  in  32  write data
- csr_read  in  1  read strobe
- csr_readdata  out  32  read data, 0 wait states, combinational on address
- irq  out  1  capture-done interrupt, level

Behaviour:
- Reset: state=IDLE; count=0; flags=0; irq_en=0; real/imag_data=0; real/imag_valid=0.
- FSM states:
  - IDLE: nothing is written.
  - ARMED: waits for sink_valid&sink_sop.
  - CAPTURE: writing samples.
  - DONE: holds results.
- Transitions:
  - IDLE/DONE → ARMED on CTRL.arm write. Count and flags clear on entry to ARMED.
  - ARMED → CAPTURE on sink_valid&sink_sop. That sample is written and count becomes 1.
  - CAPTURE, valid without sop: sample is written and count increments.
    - If it carries eop, go to DONE. If count<FRAME_LEN at that point, set SHORT.
    - If count reaches FRAME_LEN without eop, go to DONE and set LONG. Later samples are dropped.
  - CAPTURE, valid with sop (framing error): sample is not written; go to DONE and set SOPERR.
- A single-sample frame (sop&eop together) in ARMED writes 1 sample, goes to DONE, and sets SHORT.
- Arm write while ARMED or CAPTURE is ignored.
- CTRL.abort write in any state → IDLE; count and flags are preserved. Arm and abort in the same write: abort wins.
- Output path is registered, 1-cycle latency:
  - real_valid=imag_valid=1 exactly in the cycle after an accepted sample.
  - Data is the sign-extended IN_W sample.
  - Data holds its last value when valid=0.
- real_valid and imag_valid are always identical.
- irq = (state==DONE) & irq_en. It clears on leaving DONE.
- CSR map:
  - 0 CTRL: W bit0 arm (self-clearing), bit1 abort (self-clearing), bit2 irq_en (stored); R returns irq_en in bit2, others 0.
  - 1 STATUS: R bits[1:0] state (IDLE=0, ARMED=1, CAPTURE=2, DONE=3), bit4 SHORT, bit5 LONG, bit6 SOPERR. Writes are ignored.
  - 2 COUNT: R samples written in the last/current capture.
  - 3 FRAME_LEN: R parameter value.
- csr_read has no side effects.
- Asynchronous reset mid-capture returns to IDLE immediately. Downstream FIFOs share reset_n and clear together.

Optional Feature:
- Macro FFT_CAPTURE_SCALE_EN.
- Defined:
  - Adds CSR address 3 write: bits[4:0] shift (0..31, reset 0). Address 3 reads return {shift in [20:16], FRAME_LEN in [15:0]}.
  - Each sample is arithmetically right-shifted by shift with round-half-up (add 1<<(shift-1) before the shift when shift>0), computed at 33 bits and saturated to 32 bits.
  - Latency stays 1 cycle.
- Undefined: no shift logic. Address 3 writes are ignored and reads return FRAME_LEN only.

Test Plan:
- Reset, arm, 128-sample frame (sop on sample 0, eop on sample 127, real=k, imag=-k) → 128 valid pulses, each 1 cycle after its input; imag_data[5]=0xFFFFFFFB; STATUS=0x03; COUNT=128; irq=1 if irq_en.
- Unarmed frame, then arm mid-frame → nothing written until the next sop; that frame is then captured fully.
- Frame with eop at sample 9 → COUNT=10, STATUS=0x13 (SHORT). Frame with no eop → COUNT=128, LONG set, sample 128 not written.
- sop reasserted at sample 50 of a capture → COUNT=50, SOPERR set, that sample not written, real_valid low that cycle.
- Abort during CAPTURE at count 30, then arm and a fresh frame → STATUS shows IDLE with COUNT=30 after abort; next capture restarts at 0. Arm+abort in the same write → IDLE.
- FFT_CAPTURE_SCALE_EN with shift=4: input 0x0018 → 2; input 0x7FFF → 0x800; input -24 → -1 (round-half-up of -1.5). Shift=0 passes through unchanged.
